// File: rtl/diffeq_pkg.sv
// Shared types and sizes for the diffeq Euler-step scheduler.
// The job struct bundles everything captured when a start is accepted.
package diffeq_pkg;

  localparam int DIFFEQ_WIDTH  = 32;
  localparam int DIFFEQ_ITER_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_M_UDX = 3'd2,
    ST_M_TX  = 3'd3,
    ST_M_DXY = 3'd4,
    ST_UPD   = 3'd5
  } diffeq_state_t;

  typedef struct packed {
    logic [DIFFEQ_WIDTH-1:0]  x;
    logic [DIFFEQ_WIDTH-1:0]  y;
    logic [DIFFEQ_WIDTH-1:0]  u;
    logic [DIFFEQ_WIDTH-1:0]  a;
    logic [DIFFEQ_WIDTH-1:0]  dx;
    logic [DIFFEQ_ITER_W-1:0] limit;
  } diffeq_job_t;

endpackage

// File: rtl/diffeq_mul32.sv
// Registered low-half multiplier shared by the scheduler; one cycle of latency.
// Kept as its own block so a pipelined or DSP-mapped version can drop in later.
module diffeq_mul32
  import diffeq_pkg::*;
#(
  parameter int WIDTH = DIFFEQ_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] prod
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      prod <= '0;
    end else begin
      prod <= op_a * op_b;
    end
  end

endmodule

// File: rtl/diffeq_step_sched.sv
// Euler-step iteration scheduler: one shared multiplier, five cycles per iteration.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; results held
//   ST_CHECK | test x < a and the iteration limit; finish or iterate
//   ST_M_UDX | multiplier gets u*dx
//   ST_M_TX  | t <= u*dx; multiplier gets (u*dx)*x
//   ST_M_DXY | p1 <= 3*(u*dx*x); multiplier gets dx*y
//   ST_UPD   | fold products into u, y; advance x and the count
module diffeq_step_sched
  import diffeq_pkg::*;
#(
  parameter int WIDTH  = DIFFEQ_WIDTH,
  parameter int ITER_W = DIFFEQ_ITER_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  x_in,
  input  logic [WIDTH-1:0]  y_in,
  input  logic [WIDTH-1:0]  u_in,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  dx,
  input  logic [ITER_W-1:0] iter_limit,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [WIDTH-1:0]  x_out,
  output logic [WIDTH-1:0]  y_out,
  output logic [WIDTH-1:0]  u_out,
  output logic [ITER_W-1:0] iter_cnt
);

  localparam logic [ITER_W-1:0] CNT_ONE = ITER_W'(1);

  diffeq_state_t     state;
  diffeq_job_t       job;
  logic [ITER_W-1:0] cnt;
  logic [WIDTH-1:0]  t_q;
  logic [WIDTH-1:0]  p1_q;
  logic [WIDTH-1:0]  mul_a;
  logic [WIDTH-1:0]  mul_b;
  logic [WIDTH-1:0]  prod;
  logic              x_lt_a;
  logic              limit_hit;

  function automatic logic [WIDTH-1:0] times3(input logic [WIDTH-1:0] v);
    return v + (v << 1);
  endfunction

  // Operands are issued in the state that names the product; the result
  // appears on prod one state later.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      ST_M_UDX: begin
        mul_a = job.u;
        mul_b = job.dx;
      end
      ST_M_TX: begin
        mul_a = prod;
        mul_b = job.x;
      end
      ST_M_DXY: begin
        mul_a = job.dx;
        mul_b = job.y;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  diffeq_mul32 #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .op_a  (mul_a),
    .op_b  (mul_b),
    .prod  (prod)
  );

  assign x_lt_a    = (job.x < job.a);
  assign limit_hit = (job.limit != '0) && (cnt == job.limit);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      job      <= '0;
      cnt      <= '0;
      t_q      <= '0;
      p1_q     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      x_out    <= '0;
      y_out    <= '0;
      u_out    <= '0;
      iter_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            job.x     <= x_in;
            job.y     <= y_in;
            job.u     <= u_in;
            job.a     <= a;
            job.dx    <= dx;
            job.limit <= iter_limit;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (x_lt_a && !limit_hit) begin
            state <= ST_M_UDX;
          end else begin
            // Still below the bound here means the limit ended the run.
            x_out    <= job.x;
            y_out    <= job.y;
            u_out    <= job.u;
            iter_cnt <= cnt;
            timeout  <= x_lt_a;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_M_UDX: begin
          state <= ST_M_TX;
        end
        ST_M_TX: begin
          t_q   <= prod;
          state <= ST_M_DXY;
        end
        ST_M_DXY: begin
          p1_q  <= times3(prod);
          state <= ST_UPD;
        end
        ST_UPD: begin
          job.u <= job.u - p1_q - times3(prod);
          job.y <= job.y + t_q;
          job.x <= job.x + job.dx;
          cnt   <= cnt + CNT_ONE;
          state <= ST_CHECK;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_diffeq_step_sched.sv
// Scoreboard bench for diffeq_step_sched: a reference model predicts each job's
// results and done cycle; a monitor pops and compares on every done pulse.
module tb_diffeq_step_sched;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] x_in, y_in, u_in, a, dx;
  logic [15:0] iter_limit;
  logic        busy, done, timeout;
  logic [31:0] x_out, y_out, u_out;
  logic [15:0] iter_cnt;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] u;
    logic [15:0] cnt;
    logic        to;
    int          done_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  diffeq_step_sched dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .x_in       (x_in),
    .y_in       (y_in),
    .u_in       (u_in),
    .a          (a),
    .dx         (dx),
    .iter_limit (iter_limit),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .x_out      (x_out),
    .y_out      (y_out),
    .u_out      (u_out),
    .iter_cnt   (iter_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x0, input logic [31:0] y0,
                                 input logic [31:0] u0, input logic [31:0] a0,
                                 input logic [31:0] dx0, input logic [15:0] lim);
    logic [31:0] x, y, u, t, p1, q;
    logic [15:0] n;
    exp_t e;
    x = x0; y = y0; u = u0; n = '0;
    e.to = 1'b0;
    e.done_cyc = 0;
    for (int k = 0; k < 5000; k++) begin
      if (!(x < a0)) begin
        e.to = 1'b0;
        break;
      end
      if (lim != 16'd0 && n == lim) begin
        e.to = 1'b1;
        break;
      end
      t  = u * dx0;
      p1 = 32'd3 * (t * x);
      q  = 32'd3 * (dx0 * y);
      u  = u - p1 - q;
      y  = y + t;
      x  = x + dx0;
      n  = n + 16'd1;
    end
    e.x = x; e.y = y; e.u = u; e.cnt = n;
    return e;
  endfunction

  // Entered just after a negedge; returns at the negedge after the accept edge.
  task automatic run_job(input logic [31:0] x0, input logic [31:0] y0,
                         input logic [31:0] u0, input logic [31:0] a0,
                         input logic [31:0] dx0, input logic [15:0] lim);
    exp_t e;
    e = model(x0, y0, u0, a0, dx0, lim);
    x_in = x0; y_in = y0; u_in = u0; a = a0; dx = dx0; iter_limit = lim;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    e.done_cyc = cyc + 5 * int'(e.cnt) + 1;
    sb_q.push_back(e);
    check_val("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check_val("wait_done_bound", 0, 1);
      sb_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_done", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("x_out", x_out, mon_e.x);
        check_val("y_out", y_out, mon_e.y);
        check_val("u_out", u_out, mon_e.u);
        check_val("iter_cnt", iter_cnt, mon_e.cnt);
        check_val("timeout", timeout, mon_e.to);
        check_val("done_cycle", cyc, mon_e.done_cyc);
        check_val("busy_at_done", busy, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0;
    x_in = '0; y_in = '0; u_in = '0; a = '0; dx = '0; iter_limit = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_timeout", timeout, 0);
    check_val("rst_x_out", x_out, 0);
    check_val("rst_y_out", y_out, 0);
    check_val("rst_u_out", u_out, 0);
    check_val("rst_iter_cnt", iter_cnt, 0);
    reset = 1'b1;
    @(negedge clk);

    // zero iterations
    run_job(32'd0, 32'd5, 32'd7, 32'd0, 32'd1, 16'd0);
    wait_done(20);
    check_val("tp0_y", y_out, 32'd5);
    check_val("tp0_u", u_out, 32'd7);
    check_val("tp0_cnt", iter_cnt, 0);

    // one and two iterations
    run_job(32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 16'd0);
    wait_done(20);
    check_val("tp1_x", x_out, 32'd1);
    check_val("tp1_y", y_out, 32'd1);
    check_val("tp1_u", u_out, 32'd1);
    run_job(32'd0, 32'd0, 32'd1, 32'd2, 32'd1, 16'd0);
    wait_done(30);
    check_val("tp2_u", u_out, 32'hFFFF_FFFB);
    check_val("tp2_cnt", iter_cnt, 2);

    // limit terminates a stalled run
    run_job(32'd0, 32'd9, 32'd9, 32'd5, 32'd0, 16'd3);
    wait_done(40);
    check_val("lim_timeout", timeout, 1);
    check_val("lim_cnt", iter_cnt, 3);

    // x wraps past zero and only the limit stops it
    run_job(32'hFFFF_FFFE, 32'd1, 32'd2, 32'hFFFF_FFFF, 32'd2, 16'd2);
    wait_done(40);
    check_val("wrap_x", x_out, 32'd2);
    check_val("wrap_timeout", timeout, 1);

    // start while busy is ignored (would otherwise finish immediately)
    run_job(32'd0, 32'd1, 32'd1, 32'd100, 32'd0, 16'd4);
    repeat (3) @(negedge clk);
    x_in = 32'd5; a = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("busy_ignored_start", busy, 1);
    wait_done(60);
    repeat (8) @(negedge clk);

    // back-to-back: second start in the done cycle
    run_job(32'd0, 32'd2, 32'd3, 32'd1, 32'd1, 16'd0);
    wait_done(20);
    check_val("b2b_done_high", done, 1);
    run_job(32'd3, 32'd4, 32'd5, 32'd9, 32'd3, 16'd0);
    wait_done(30);
    check_val("b2b_x", x_out, 32'd9);

    // reset while in M_TX discards the job and clears outputs
    run_job(32'd0, 32'd1, 32'd1, 32'd100, 32'd0, 16'd50);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    sb_q.delete();
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_done", done, 0);
    check_val("mid_rst_timeout", timeout, 0);
    check_val("mid_rst_x_out", x_out, 0);
    check_val("mid_rst_y_out", y_out, 0);
    check_val("mid_rst_u_out", u_out, 0);
    check_val("mid_rst_iter_cnt", iter_cnt, 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check_val("post_rst_idle_busy", busy, 0);

    run_job(32'd1, 32'd1, 32'd1, 32'd3, 32'd1, 16'd0);
    wait_done(30);

    // random jobs with small limits
    for (int i = 0; i < 8; i++) begin
      run_job($urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
              16'($urandom_range(1, 5)));
      wait_done(40);
    end

    repeat (5) @(negedge clk);
    check_val("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/diffeq_step_sched.md
# diffeq_step_sched

Iteration scheduler for the diffeq Euler-step solver. It owns a single shared 32x32 multiplier and time-multiplexes it across the three products each step needs: u·dx, t·x and dx·y. It accepts a job with a start pulse, iterates until `x >= a` or an optional iteration limit is reached, then presents results with a one-cycle done pulse. It replaces the three-multiplier loop with a one-multiplier, 5-cycle-per-iteration sequence.

## Interface
- `WIDTH`, 32, datapath width; all arithmetic is unsigned modulo 2^WIDTH.
- `ITER_W`, 16, width of the iteration counter and limit.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset (`reset==0` resets on the clock edge).
- `start`  in  1  job request; sampled only in IDLE.
- `x_in`, `y_in`, `u_in`  in  WIDTH  initial x, y, u; captured on an accepted start.
- `a`  in  WIDTH  x bound; captured on an accepted start.
- `dx`  in  WIDTH  step; captured on an accepted start.
- `iter_limit`  in  ITER_W  maximum iterations; 0 means unlimited. Captured on an accepted start.
- `busy`  out  1  high from the cycle after an accepted start until done.
- `done`  out  1  one-cycle pulse; result outputs are valid.
- `timeout`  out  1  valid with done; 1 means the limit terminated the run.
- `x_out`, `y_out`, `u_out`  out  WIDTH  results; held until the next done.
- `iter_cnt`  out  ITER_W  iterations executed; held with the results.

## Operation
- States: IDLE, CHECK, M_UDX, M_TX, M_DXY, UPD.
- **IDLE**
  - If `start`: load x, y, u, a, dx and limit into working registers; clear the count; go to CHECK.
  - Otherwise stay in IDLE.
- **CHECK** (the comparison is unsigned)
  - If `x < a` and (`limit == 0` or `cnt != limit`): go to M_UDX.
  - If `x < a` and `cnt == limit`: finish with `timeout = 1`.
  - Otherwise: finish with `timeout = 0`.
- **Finish** registers the following on the CHECK exit edge:
  - `x_out`/`y_out`/`u_out`/`iter_cnt` take the working values.
  - `done = 1`, `busy = 0`.
  - The state returns to IDLE.
- **M_UDX**: issue u·dx to the multiplier.
- **M_TX**: `t <= prod`; issue prod·x.
- **M_DXY**: `p1 <= 3·prod`; issue dx·y.
- **UPD**: `u <= u − p1 − 3·prod`; `y <= y + t`; `x <= x + dx`; `cnt <= cnt + 1`; go to CHECK.
- **Arithmetic**
  - Products keep the low WIDTH bits.
  - ×3 is computed as `v + (v<<1)`, truncated.
  - All adds and subtracts wrap. An x wrap-around is not detected; the run continues, and termination relies on `iter_limit`.
- **Boundary behaviour**
  - `start` while busy is ignored.
  - `start` in the cycle done is high is accepted, because the FSM is already in IDLE.
  - If `dx == 0` and `x < a` with limit 0, the block never terminates. This is legal; the caller supplies a limit.
  - If `cnt` reaches 2^ITER_W−1 with limit 0, it wraps. The caller is responsible for avoiding this.
- **Reset** (`reset == 0`), including mid-iteration:
  - FSM returns to IDLE.
  - `busy`, `done` and `timeout` go to 0.
  - `x_out`, `y_out`, `u_out` and `iter_cnt` go to 0.
  - All working registers and the multiplier output go to 0.
  - Any job in progress is discarded.

## Timing
- Start is accepted on edge E0.
- A run of N iterations produces done on edge E(5N+1); done is high in the cycle that follows that edge.
  - N = 0 gives 1 edge.
  - N = 1 gives 6 edges.
- `busy` falls on the same edge that `done` rises.
- Multiplier latency is exactly 1 cycle: operands are issued in state S, and `prod` is valid in state S+1.
- Outputs change only on the done edge or on reset.

## Structure
- **Package `diffeq_pkg`**:
  - State enum.
  - `DIFFEQ_WIDTH = 32`.
  - `DIFFEQ_ITER_W = 16`.
  - A `diffeq_job_t` struct holding x, y, u, a, dx and limit.
- **Sub-module `diffeq_mul32`**:
  - Registered WIDTH×WIDTH low-half multiplier: inputs `op_a` and `op_b`, output `prod`.
  - Synchronous active-low clear.
  - Keeping it separate leaves room for a later pipelined or DSP-mapped variant.
- **Top level**: operand mux, FSM, working registers and output registers.

## Test plan
- **No iterations**: x=0, a=0, y=5, u=7, dx=1 → done at E1; outputs (0, 5, 7); iter_cnt 0; timeout 0.
- **One iteration**: x=0, y=0, u=1, dx=1, a=1 → done at E6; outputs x 1, y 1, u 1; iter_cnt 1.
- **Two iterations**: same job with a=2 → done at E11; x 2, y 2, u 0xFFFF_FFFB (1−3−3); iter_cnt 2.
- **Limit**: dx=0, x=0, a=5, iter_limit=3 → done at E16; timeout 1; iter_cnt 3; x_out 0.
- **Wrap-around**: x=0xFFFF_FFFE, dx=2, a=0xFFFF_FFFF, limit 2 → timeout 1; x_out 2; iter_cnt 2.
- **Control**:
  - Pulse start during busy → it is ignored.
  - Assert `reset=0` in M_TX → next cycle shows IDLE, all outputs 0, and no done.
  - Start back-to-back in the done cycle → the second job is accepted.
